mac_rx_interface: RTL and testbench

Receive-side companion of the NIC-to-MAC transmit path. It accepts frames from the MAC receive AXI-stream, which has no tready, and buffers them store-and-forward in an internal queue. Only complete, good frames are presented to the NIC on the RX_FIFO pipe read handshake. Frames flagged bad by the MAC (tuser) and frames that overflow the queue are discarded whole.

---
 rtl/mac_if_pkg.sv | 22 ++
 rtl/mac_rx_interface_if.sv | 27 ++
 rtl/mac_rx_queue_ram.sv | 34 +++
 rtl/mac_rx_interface.sv | 108 ++++++++++
 tb/tb_mac_rx_interface.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_if_pkg.sv
// Shared MAC/NIC pipe definitions: field positions of the packed pipe word and
// the receive-side frame states.
package mac_if_pkg;

  localparam int MAC_WIDTH   = 64;
  localparam int TKEEP_WIDTH = MAC_WIDTH / 8;
  localparam int NIC_WIDTH   = MAC_WIDTH + TKEEP_WIDTH + 1;

  // Pipe word layout: {tlast, tdata, tkeep}
  localparam int TLAST_BIT = NIC_WIDTH - 1;
  localparam int TDATA_HI  = NIC_WIDTH - 2;
  localparam int TDATA_LO  = TKEEP_WIDTH;
  localparam int TKEEP_HI  = TKEEP_WIDTH - 1;
  localparam int TKEEP_LO  = 0;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DROP
  } rx_state_t;

endpackage

// File: rtl/mac_rx_interface_if.sv
// MAC receive AXI-stream plus the NIC-facing RX_FIFO pipe read handshake.
interface mac_rx_interface_if;
  import mac_if_pkg::*;

  logic [MAC_WIDTH-1:0]   rx_axis_tdata;
  logic [TKEEP_WIDTH-1:0] rx_axis_tkeep;
  logic                   rx_axis_tvalid;
  logic                   rx_axis_tlast;
  logic                   rx_axis_tuser;

  logic [NIC_WIDTH-1:0]   RX_FIFO_pipe_read_data;
  logic                   RX_FIFO_pipe_read_req;
  logic                   RX_FIFO_pipe_read_ack;

  modport master (
    output rx_axis_tdata, rx_axis_tkeep, rx_axis_tvalid, rx_axis_tlast, rx_axis_tuser,
    output RX_FIFO_pipe_read_req,
    input  RX_FIFO_pipe_read_data, RX_FIFO_pipe_read_ack
  );

  modport slave (
    input  rx_axis_tdata, rx_axis_tkeep, rx_axis_tvalid, rx_axis_tlast, rx_axis_tuser,
    input  RX_FIFO_pipe_read_req,
    output RX_FIFO_pipe_read_data, RX_FIFO_pipe_read_ack
  );

endinterface

// File: rtl/mac_rx_queue_ram.sv
// Simple dual-port frame queue storage: one write port and one synchronous
// read port whose output register doubles as the NIC head word.
module mac_rx_queue_ram #(
  parameter int NIC_WIDTH  = 73,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [NIC_WIDTH-1:0]  wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [NIC_WIDTH-1:0]  rd_data
);

  logic [NIC_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Only the output register is reset so a reset also clears the head word.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/mac_rx_interface.sv
// Store-and-forward MAC receive buffer: frames are written speculatively and
// only complete good frames become visible on the NIC RX_FIFO read pipe.
module mac_rx_interface
  import mac_if_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  mac_rx_interface_if.slave    rx,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic [CNT_WIDTH-1:0] drop_count
);

  rx_state_t             state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] commit_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  full;
  logic                  avail;
  logic                  store;
  logic                  head_load;
  logic                  head_ack;
  logic [NIC_WIDTH-1:0]  wr_word;
  logic [NIC_WIDTH-1:0]  head_data;

  assign full      = (wr_ptr + ADDR_WIDTH'(1)) == rd_ptr;
  assign avail     = rd_ptr != commit_ptr;
  assign store     = rx.rx_axis_tvalid && (state != DROP) && !full;
  assign head_load = avail && (!head_ack || rx.RX_FIFO_pipe_read_req);

  always_comb begin
    wr_word                    = '0;
    wr_word[TLAST_BIT]         = rx.rx_axis_tlast;
    wr_word[TDATA_HI:TDATA_LO] = rx.rx_axis_tdata;
    wr_word[TKEEP_HI:TKEEP_LO] = rx.rx_axis_tkeep;
  end

  mac_rx_queue_ram #(
    .NIC_WIDTH  (NIC_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (store),
    .wr_addr (wr_ptr),
    .wr_data (wr_word),
    .rd_en   (head_load),
    .rd_addr (rd_ptr),
    .rd_data (head_data)
  );

  assign rx.RX_FIFO_pipe_read_data = head_data;
  assign rx.RX_FIFO_pipe_read_ack  = head_ack;

  // Rewinding wr_ptr to commit_ptr discards a partial frame and frees its space at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      commit_ptr  <= '0;
      frame_count <= '0;
      drop_count  <= '0;
    end else if (rx.rx_axis_tvalid) begin
      case (state)
        IDLE, RECV: begin
          if (full) begin
            wr_ptr     <= commit_ptr;
            drop_count <= drop_count + CNT_WIDTH'(1);
            state      <= rx.rx_axis_tlast ? IDLE : DROP;
          end else if (rx.rx_axis_tlast && rx.rx_axis_tuser) begin
            wr_ptr     <= commit_ptr;
            drop_count <= drop_count + CNT_WIDTH'(1);
            state      <= IDLE;
          end else if (rx.rx_axis_tlast) begin
            wr_ptr      <= wr_ptr + ADDR_WIDTH'(1);
            commit_ptr  <= wr_ptr + ADDR_WIDTH'(1);
            frame_count <= frame_count + CNT_WIDTH'(1);
            state       <= IDLE;
          end else begin
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            state  <= RECV;
          end
        end
        DROP: begin
          if (rx.rx_axis_tlast) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      head_ack <= 1'b0;
    end else if (head_load) begin
      rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
      head_ack <= 1'b1;
    end else if (head_ack && rx.RX_FIFO_pipe_read_req) begin
      head_ack <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_rx_interface.sv
// Randomized frame traffic against a frame-level model: good frames are queued
// word by word, bad or oversized frames only bump the drop count.
module tb_mac_rx_interface;
  import mac_if_pkg::*;

  localparam int ADDR_W = 9;
  localparam int CNT_W  = 16;

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic [CNT_W-1:0] frame_count;
  logic [CNT_W-1:0] drop_count;

  mac_rx_interface_if rx();

  mac_rx_interface #(
    .ADDR_WIDTH (ADDR_W),
    .CNT_WIDTH  (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .frame_count (frame_count),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int exp_frames  = 0;
  int exp_drops   = 0;
  logic [NIC_WIDTH-1:0] exp_q[$];
  logic [NIC_WIDTH-1:0] got_q[$];
  bit gap_check_en = 0;
  bit in_frame     = 0;
  int gap_count    = 0;

  // Collect every word the NIC actually takes; sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      in_frame = 0;
    end else begin
      if (gap_check_en && in_frame && !rx.RX_FIFO_pipe_read_ack) gap_count++;
      if (rx.RX_FIFO_pipe_read_ack && rx.RX_FIFO_pipe_read_req) begin
        got_q.push_back(rx.RX_FIFO_pipe_read_data);
        in_frame = !rx.RX_FIFO_pipe_read_data[TLAST_BIT];
      end
    end
  end

  task automatic drive_beat(input logic [MAC_WIDTH-1:0] d, input logic [TKEEP_WIDTH-1:0] k,
                            input logic last, input logic user);
    rx.rx_axis_tvalid = 1'b1;
    rx.rx_axis_tdata  = d;
    rx.rx_axis_tkeep  = k;
    rx.rx_axis_tlast  = last;
    rx.rx_axis_tuser  = user;
    @(posedge clk);
    #1;
    rx.rx_axis_tvalid = 1'b0;
    rx.rx_axis_tlast  = 1'b0;
    rx.rx_axis_tuser  = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit tuser_last, input bit expect_good);
    logic [MAC_WIDTH-1:0]   d;
    logic [TKEEP_WIDTH-1:0] k;
    logic                   last;
    for (int b = 0; b < len; b++) begin
      d    = {$urandom(), $urandom()};
      last = (b == len - 1);
      k    = last ? TKEEP_WIDTH'($urandom_range(1, 255)) : 8'hFF;
      if (expect_good) exp_q.push_back({last, d, k});
      drive_beat(d, k, last, last ? tuser_last : 1'($urandom_range(0, 1)));
    end
    if (expect_good) exp_frames++;
    else exp_drops++;
  endtask

  task automatic wait_drain(output bit timed_out);
    timed_out = 1;
    for (int c = 0; c < 3000; c++) begin
      if (got_q.size() >= exp_q.size()) begin
        timed_out = 0;
        break;
      end
      @(posedge clk);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  // mode 0: req always 1, mode 1: alternate 1/0, mode 2: random.
  task automatic run_traffic(input int n, input int minlen, input int maxlen,
                             input int badpct, input int gapmax, input int mode);
    bit                   done;
    bit                   held;
    logic [NIC_WIDTH-1:0] held_data;
    done = 0;
    held = 0;
    held_data = '0;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          int  len;
          int  gap;
          bit  bad;
          len = $urandom_range(minlen, maxlen);
          bad = ($urandom_range(0, 99) < badpct);
          send_frame(len, bad, !bad);
          gap = $urandom_range(0, gapmax);
          for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
          end
        end
        done = 1;
      end
      begin
        for (int c = 0; c < 20000; c++) begin
          if (done && got_q.size() >= exp_q.size()) break;
          @(posedge clk);
          #1;
          case (mode)
            0:       rx.RX_FIFO_pipe_read_req = 1'b1;
            1:       rx.RX_FIFO_pipe_read_req = ((c % 2) == 0);
            default: rx.RX_FIFO_pipe_read_req = 1'($urandom_range(0, 1));
          endcase
          @(negedge clk);
          if (held) begin
            vectors++;
            if (rx.RX_FIFO_pipe_read_ack !== 1'b1 || rx.RX_FIFO_pipe_read_data !== held_data) begin
              miscompares++;
              $display("[TB] FAIL hold_stable: ack=%b data=%h, required ack=1 data=%h",
                       rx.RX_FIFO_pipe_read_ack, rx.RX_FIFO_pipe_read_data, held_data);
            end
          end
          held      = rx.RX_FIFO_pipe_read_ack && !rx.RX_FIFO_pipe_read_req;
          held_data = rx.RX_FIFO_pipe_read_data;
        end
      end
    join
  endtask

  task automatic check_words(input string name, input bit timed_out);
    vectors++;
    if (timed_out) begin
      miscompares++;
      $display("[TB] FAIL %s_drain: timed out with %0d of %0d words", name, got_q.size(), exp_q.size());
    end
    vectors++;
    if (got_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("[TB] FAIL %s_len: got %0d words, required %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("[TB] FAIL %s_word[%0d]: got %h, required %h", name, i, got_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (frame_count !== CNT_W'(exp_frames) || drop_count !== CNT_W'(exp_drops)) begin
      miscompares++;
      $display("[TB] FAIL %s_counts: frames=%0d drops=%0d, required frames=%0d drops=%0d",
               name, frame_count, drop_count, CNT_W'(exp_frames), CNT_W'(exp_drops));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    rx.rx_axis_tvalid = 1'b0;
    rx.rx_axis_tdata  = '0;
    rx.rx_axis_tkeep  = '0;
    rx.rx_axis_tlast  = 1'b0;
    rx.rx_axis_tuser  = 1'b0;
    rx.RX_FIFO_pipe_read_req = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (rx.RX_FIFO_pipe_read_ack !== 1'b0 || rx.RX_FIFO_pipe_read_data !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_head: ack=%b data=%h, required ack=0 data=0",
               rx.RX_FIFO_pipe_read_ack, rx.RX_FIFO_pipe_read_data);
    end
    vectors++;
    if (frame_count !== '0 || drop_count !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_counts: frames=%0d drops=%0d, required 0 and 0", frame_count, drop_count);
    end
  endtask

  task automatic test_good_frame();
    bit to;
    logic [NIC_WIDTH-1:0] w0;
    w0 = {1'b0, 64'h1111_1111_1111_1111, 8'hFF};
    exp_q.push_back(w0);
    exp_q.push_back({1'b0, 64'h2222_2222_2222_2222, 8'hFF});
    exp_q.push_back({1'b1, 64'h3333_3333_3333_3333, 8'h0F});
    exp_frames++;
    @(posedge clk);
    #1;
    rx.RX_FIFO_pipe_read_req = 1'b1;
    drive_beat(64'h1111_1111_1111_1111, 8'hFF, 1'b0, 1'b0);
    drive_beat(64'h2222_2222_2222_2222, 8'hFF, 1'b0, 1'b0);
    drive_beat(64'h3333_3333_3333_3333, 8'h0F, 1'b1, 1'b0);
    @(negedge clk);
    vectors++;
    if (rx.RX_FIFO_pipe_read_ack !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL good_latency_early: ack=%b one cycle after tlast, required 0", rx.RX_FIFO_pipe_read_ack);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (rx.RX_FIFO_pipe_read_ack !== 1'b1 || rx.RX_FIFO_pipe_read_data !== w0) begin
      miscompares++;
      $display("[TB] FAIL good_latency_first: ack=%b data=%h, required ack=1 data=%h",
               rx.RX_FIFO_pipe_read_ack, rx.RX_FIFO_pipe_read_data, w0);
    end
    wait_drain(to);
    check_words("good", to);
  endtask

  task automatic test_bad_frame();
    bit to;
    rx.RX_FIFO_pipe_read_req = 1'b1;
    send_frame(4, 1'b1, 1'b0);
    send_frame(1, 1'b0, 1'b1);
    wait_drain(to);
    check_words("bad", to);
  endtask

  task automatic test_random();
    bit to;
    run_traffic(20, 1, 8, 30, 2, 2);
    rx.RX_FIFO_pipe_read_req = 1'b1;
    wait_drain(to);
    check_words("random", to);
  endtask

  task automatic test_overflow();
    bit to;
    rx.RX_FIFO_pipe_read_req = 1'b0;
    // 300 words fit in the 511-entry queue; another 300 on top cannot.
    send_frame(300, 1'b0, 1'b1);
    send_frame(300, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (rx.RX_FIFO_pipe_read_ack !== 1'b1 || rx.RX_FIFO_pipe_read_data !== exp_q[0]) begin
      miscompares++;
      $display("[TB] FAIL overflow_head: ack=%b data=%h, required ack=1 data=%h",
               rx.RX_FIFO_pipe_read_ack, rx.RX_FIFO_pipe_read_data, exp_q[0]);
    end
    rx.RX_FIFO_pipe_read_req = 1'b1;
    wait_drain(to);
    vectors++;
    if (got_q.size() != 300 || got_q[got_q.size()-1][TLAST_BIT] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL overflow_last: got %0d words, required 300 ending in tlast", got_q.size());
    end
    check_words("overflow", to);
  endtask

  task automatic test_back_to_back();
    bit to;
    gap_count    = 0;
    gap_check_en = 1;
    run_traffic(20, 60, 60, 0, 0, 0);
    wait_drain(to);
    gap_check_en = 0;
    vectors++;
    if (gap_count !== 0) begin
      miscompares++;
      $display("[TB] FAIL throughput_gaps: %0d idle cycles inside frames, required 0", gap_count);
    end
    check_words("throughput", to);
  endtask

  task automatic test_backpressure();
    bit to;
    run_traffic(6, 2, 6, 0, 1, 1);
    rx.RX_FIFO_pipe_read_req = 1'b1;
    wait_drain(to);
    check_words("backpressure", to);
  endtask

  task automatic test_reset_mid();
    bit to;
    rx.RX_FIFO_pipe_read_req = 1'b0;
    send_frame(3, 1'b0, 1'b1);
    drive_beat({$urandom(), $urandom()}, 8'hFF, 1'b0, 1'b0);
    rx.rx_axis_tvalid = 1'b1;
    rx.rx_axis_tdata  = {$urandom(), $urandom()};
    rx.rx_axis_tkeep  = 8'hFF;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rx.rx_axis_tvalid = 1'b0;
    exp_q.delete();
    got_q.delete();
    exp_frames = 0;
    exp_drops  = 0;
    @(negedge clk);
    vectors++;
    if (rx.RX_FIFO_pipe_read_ack !== 1'b0 || frame_count !== '0 || drop_count !== '0) begin
      miscompares++;
      $display("[TB] FAIL midreset_state: ack=%b frames=%0d drops=%0d, required all 0",
               rx.RX_FIFO_pipe_read_ack, frame_count, drop_count);
    end
    rx.RX_FIFO_pipe_read_req = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (got_q.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL midreset_empty: %0d words delivered after reset, required 0", got_q.size());
    end
    send_frame(2, 1'b0, 1'b1);
    wait_drain(to);
    check_words("midreset", to);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_frame();
    test_random();
    test_overflow();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
